// File: rtl/jt900h_muldiv_pkg.sv
// Shared encodings for the JT900H multiply/divide unit.
// The control unit imports the same op and state codes.
package jt900h_muldiv_pkg;

   typedef enum logic [1:0] {
      MD_MUL  = 2'd0,
      MD_MULS = 2'd1,
      MD_DIV  = 2'd2,
      MD_DIVS = 2'd3
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_FIX  = 2'd2
   } md_st_e;

endpackage

// File: rtl/jt900h_muldiv_if.sv
// Request/response bundle between the control unit (master) and muldiv (slave).
interface jt900h_muldiv_if #(parameter int W = 16);
   import jt900h_muldiv_pkg::*;

   logic           start;
   md_op_e         op;
   logic           wide;
   logic [2*W-1:0] a;
   logic [W-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*W-1:0] dout;
   logic           ovf;

   modport master (output start, op, wide, a, b, input busy, done, dout, ovf);
   modport slave  (input start, op, wide, a, b, output busy, done, dout, ovf);

endinterface

// File: rtl/jt900h_muldiv_step.sv
// One radix-2 step: right-shift add for multiply, restoring left-shift
// subtract for divide. Partial is {hi, lo}; the quotient bit goes to the caller.
module jt900h_muldiv_step #(parameter int W = 16) (
   input  logic [2*W-1:0] part_i,
   input  logic [W-1:0]   opnd_i,
   input  logic           div_i,
   output logic [2*W-1:0] part_o,
   output logic           q_o
);

   logic [W-1:0] hi, lo, dif;
   logic [W:0]   sum, shl;

   always_comb begin
      hi  = part_i[2*W-1:W];
      lo  = part_i[W-1:0];
      sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd_i} : {(W+1){1'b0}});
      shl = {hi, lo[W-1]};
      // the remainder after a successful subtract is below the divisor, so W bits suffice
      dif = shl[W-1:0] - opnd_i;
      q_o = 1'b0;
      if (div_i) begin
         q_o    = shl >= {1'b0, opnd_i};
         part_o = {(q_o ? dif : shl[W-1:0]), lo[W-2:0], 1'b0};
      end else begin
         part_o = {sum, lo[W-1:1]};
      end
   end

endmodule

// File: rtl/jt900h_muldiv.sv
// Iterative MUL/MULS/DIV/DIVS for the JT900H, byte (W/2) or word (W) operands.
// Signed ops run on magnitudes; signs are reapplied in FIX.
module jt900h_muldiv
   import jt900h_muldiv_pkg::*;
#(parameter int W = 16) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           cen_i,
   jt900h_muldiv_if.slave md
);

   localparam int H  = W / 2;
   localparam int CW = $clog2(W + 1);

   md_st_e         st_q;
   logic [CW-1:0]  cnt_q;
   logic [2*W-1:0] p_q, a_q, dout_q;
   logic [W-1:0]   opnd_q;
   logic           div_q, sgn_q, wide_q, neg_q, rneg_q, eo_q, povf_q;
   logic           busy_q, done_q, ovf_q;

   // operand preparation, evaluated while idle
   logic [1:0]     opv;
   logic [W-1:0]   nmask, an, bn, amag, bmag, dhi, dlo, opnd_init;
   logic [2*W-1:0] dn, dneg, dmag, p_init;
   logic           sa, sb, sd, eo, povf, neg, rneg;

   always_comb begin
      opv   = md.op;
      nmask = md.wide ? {W{1'b1}} : {{(W-H){1'b0}}, {H{1'b1}}};
      an    = md.a[W-1:0] & nmask;
      bn    = md.b & nmask;
      sa    = md.wide ? md.a[W-1]   : md.a[H-1];
      sb    = md.wide ? md.b[W-1]   : md.b[H-1];
      sd    = md.wide ? md.a[2*W-1] : md.a[W-1];
      dn    = md.wide ? md.a : {{W{1'b0}}, md.a[W-1:0]};
      amag  = ((opv[0] && sa) ? -an : an) & nmask;
      bmag  = ((opv[0] && sb) ? -bn : bn) & nmask;
      dneg  = (opv[0] && sd) ? -dn : dn;
      dmag  = md.wide ? dneg : {{W{1'b0}}, dneg[W-1:0]};
      // byte dividends sit in the top of lo so the quotient lands in the low half
      dhi   = md.wide ? dmag[2*W-1:W] : {{H{1'b0}}, dmag[W-1:H]};
      dlo   = md.wide ? dmag[W-1:0]   : {dmag[H-1:0], {H{1'b0}}};
      povf  = dhi >= bmag;
      eo    = opv[1] && (bmag == '0 || (!opv[0] && povf));
      neg   = opv[0] && (opv[1] ? (sd ^ sb) : (sa ^ sb));
      rneg  = opv[0] && sd;
      p_init    = opv[1] ? {dhi, dlo} : {{W{1'b0}}, bmag};
      opnd_init = opv[1] ? bmag : amag;
   end

   logic [2*W-1:0] step_p, p_d;
   logic           step_q;

   jt900h_muldiv_step #(.W(W)) u_step (
      .part_i (p_q),
      .opnd_i (opnd_q),
      .div_i  (div_q),
      .part_o (step_p),
      .q_o    (step_q)
   );

   assign p_d = {step_p[2*W-1:1], div_q ? step_q : step_p[0]};

   // sign fix-up and overflow decision
   logic [2*W-1:0] pmag, pres, dout_d;
   logic [W-1:0]   rmag, qmag, rres, qres, hbit;
   logic           qovf, ovf_d;

   always_comb begin
      hbit  = wide_q ? {1'b1, {(W-1){1'b0}}} : {{H{1'b0}}, 1'b1, {(H-1){1'b0}}};
      pmag  = wide_q ? p_q : (p_q >> H);
      pres  = neg_q ? -pmag : pmag;
      rmag  = p_q[2*W-1:W];
      qmag  = p_q[W-1:0];
      rres  = rneg_q ? -rmag : rmag;
      qres  = neg_q ? -qmag : qmag;
      // a negative quotient may reach -2^(n-1); a positive one stops at 2^(n-1)-1
      qovf  = sgn_q && (povf_q || qmag > (neg_q ? hbit : hbit - W'(1)));
      ovf_d = div_q && (eo_q || qovf);
      if (!div_q)
         dout_d = wide_q ? pres : {{W{1'b0}}, pres[W-1:0]};
      else if (ovf_d)
         dout_d = a_q;
      else
         dout_d = wide_q ? {rres, qres} : {{W{1'b0}}, rres[H-1:0], qres[H-1:0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= MD_IDLE;
         cnt_q  <= '0;
         p_q    <= '0;
         a_q    <= '0;
         opnd_q <= '0;
         div_q  <= 1'b0;
         sgn_q  <= 1'b0;
         wide_q <= 1'b0;
         neg_q  <= 1'b0;
         rneg_q <= 1'b0;
         eo_q   <= 1'b0;
         povf_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         dout_q <= '0;
         ovf_q  <= 1'b0;
      end else if (cen_i) begin
         done_q <= 1'b0;
         case (st_q)
            MD_IDLE: if (md.start) begin
               p_q    <= p_init;
               a_q    <= md.a;
               opnd_q <= opnd_init;
               div_q  <= opv[1];
               sgn_q  <= opv[0];
               wide_q <= md.wide;
               neg_q  <= neg;
               rneg_q <= rneg;
               eo_q   <= eo;
               povf_q <= povf;
               cnt_q  <= md.wide ? CW'(W) : CW'(H);
               busy_q <= 1'b1;
               st_q   <= eo ? MD_FIX : MD_RUN;
            end
            MD_RUN: begin
               p_q   <= p_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) st_q <= MD_FIX;
            end
            MD_FIX: begin
               dout_q <= dout_d;
               ovf_q  <= ovf_d;
               done_q <= 1'b1;
               busy_q <= 1'b0;
               st_q   <= MD_IDLE;
            end
            default: st_q <= MD_IDLE;
         endcase
      end
   end

   assign md.busy = busy_q;
   assign md.done = done_q;
   assign md.dout = dout_q;
   assign md.ovf  = ovf_q;

endmodule

// File: tb/tb_jt900h_muldiv.sv
// Scoreboard bench for jt900h_muldiv: directed cases plus random ops against an arithmetic model.
module tb_jt900h_muldiv;
   import jt900h_muldiv_pkg::*;

   localparam int W = 16;
   localparam int H = W / 2;

   typedef struct {
      logic [2*W-1:0] dout;
      logic           ovf;
      int             lat;
      int             e0;
      string          name;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cen = 1'b1;
   bit   cen_tog = 1'b0;
   int   errors = 0, checks = 0, ecnt = 0;
   exp_t sb[$];

   jt900h_muldiv_if #(.W(W)) md();

   jt900h_muldiv #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cen_i (cen),
      .md    (md)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rst_n && cen) ecnt <= ecnt + 1;

   initial forever begin
      @(negedge clk);
      cen = cen_tog ? ~cen : 1'b1;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(posedge clk) begin : mon
      bit   en;
      exp_t e;
      en = cen && rst_n;
      #1;
      if (en && rst_n && md.done) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: dout=%0h with no pending op", md.dout);
         end else begin
            e = sb.pop_front();
            chk({e.name, " dout"}, md.dout, e.dout);
            chk({e.name, " ovf"}, md.ovf, e.ovf);
            chk({e.name, " latency"}, ecnt - 1 - e.e0, e.lat);
            chk({e.name, " busy_at_done"}, md.busy, 0);
         end
      end
   end

   function automatic longint sx(input longint v, input int k);
      longint m, r;
      m = (longint'(1) << k) - 1;
      r = v & m;
      if (r[k-1]) r = r - (longint'(1) << k);
      return r;
   endfunction

   // arithmetic reference: plain signed/unsigned math on n-bit operands
   task automatic model(input md_op_e op, input bit wide, input logic [2*W-1:0] a,
                        input logic [W-1:0] b, output logic [2*W-1:0] xd,
                        output bit xo, output int xl);
      int n;
      longint m1, m2, x, y, q, r;
      n  = wide ? W : H;
      m1 = (longint'(1) << n) - 1;
      m2 = (longint'(1) << (2*n)) - 1;
      xo = 1'b0; xl = n + 1; xd = '0;
      case (op)
         MD_MUL:  xd = (2*W)'(((longint'(a) & m1) * (longint'(b) & m1)) & m2);
         MD_MULS: xd = (2*W)'((sx(longint'(a), n) * sx(longint'(b), n)) & m2);
         MD_DIV: begin
            x = longint'(a) & m2;
            y = longint'(b) & m1;
            if (y == 0 || x / y > m1) begin
               xo = 1'b1; xl = 1; xd = a;
            end else
               xd = (2*W)'(((x % y) << n) | (x / y));
         end
         default: begin
            x = sx(longint'(a), 2*n);
            y = sx(longint'(b), n);
            if (y == 0) begin
               xo = 1'b1; xl = 1; xd = a;
            end else begin
               q = x / y;
               r = x % y;
               if (q > (m1 >> 1) || q < -((m1 >> 1) + 1)) begin
                  xo = 1'b1; xd = a;
               end else
                  xd = (2*W)'(((r & m1) << n) | (q & m1));
            end
         end
      endcase
   endtask

   task automatic issue(input string nm, input md_op_e op, input bit wide,
                        input logic [2*W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] xd, input bit xo, input int xl, input bit junk);
      int   t;
      bit   ok;
      exp_t e;
      t = 0;
      @(negedge clk);
      while (md.busy && t < 300) begin @(negedge clk); t++; end
      if (md.busy) begin
         checks++; errors++;
         $display("FAIL %s idle_wait: busy still high after %0d cycles", nm, t);
         return;
      end
      md.op = op; md.wide = wide; md.a = a; md.b = b; md.start = 1'b1;
      ok = 1'b0; t = 0;
      while (!ok && t < 300) begin
         @(posedge clk);
         if (cen) begin
            ok = 1'b1;
            e.e0 = ecnt;
         end
         t++;
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL %s accept: no enabled edge within %0d cycles", nm, t);
         md.start = 1'b0;
         return;
      end
      e.dout = xd; e.ovf = xo; e.lat = xl; e.name = nm;
      sb.push_back(e);
      #1 chk({nm, " busy_after_start"}, md.busy, 1);
      @(negedge clk);
      md.start = 1'b0;
      if (junk && md.busy) begin
         md.start = 1'b1;
         md.op    = md_op_e'($urandom_range(0, 3));
         md.a     = (2*W)'($urandom);
         md.b     = W'($urandom);
         @(negedge clk);
         md.start = 1'b0;
      end
   endtask

   task automatic rand_op(input string nm);
      md_op_e         op;
      bit             wide;
      int             n, sel;
      logic [2*W-1:0] a, xd;
      logic [W-1:0]   b;
      bit             xo;
      int             xl;
      op   = md_op_e'($urandom_range(0, 3));
      wide = 1'($urandom_range(0, 1));
      n    = wide ? W : H;
      a    = (2*W)'({$urandom, $urandom});
      b    = W'($urandom);
      sel  = $urandom_range(0, 7);
      if (sel == 0) b = '0;
      else if (sel <= 4) a = (2*W)'(sx(longint'(a), n));
      if (!wide) a[2*W-1:W] = '0;
      model(op, wide, a, b, xd, xo, xl);
      issue(nm, op, wide, a, b, xd, xo, xl, 1'b0);
   endtask

   initial begin : stim
      int t;
      md.start = 1'b0; md.op = MD_MUL; md.wide = 1'b0; md.a = '0; md.b = '0;
      repeat (3) @(negedge clk);
      chk("reset busy", md.busy, 0);
      chk("reset done", md.done, 0);
      chk("reset dout", md.dout, 0);
      chk("reset ovf",  md.ovf,  0);
      rst_n = 1'b1;

      issue("mul_w",        MD_MUL,  1'b1, 32'h00001234, 16'h5678, 32'h06260060, 1'b0, 17, 1'b1);
      issue("muls_b",       MD_MULS, 1'b0, 32'h000000FE, 16'h0003, 32'h0000FFFA, 1'b0, 9,  1'b0);
      issue("div_w",        MD_DIV,  1'b1, 32'h00010000, 16'h0003, 32'h00015555, 1'b0, 17, 1'b0);
      issue("divs_b",       MD_DIVS, 1'b0, 32'h0000FFF9, 16'h0002, 32'h0000FFFD, 1'b0, 9,  1'b0);
      issue("div_w_zero",   MD_DIV,  1'b1, 32'h00001234, 16'h0000, 32'h00001234, 1'b1, 1,  1'b1);
      issue("div_w_hi",     MD_DIV,  1'b1, 32'h00050000, 16'h0004, 32'h00050000, 1'b1, 1,  1'b0);
      issue("divs_b_minq",  MD_DIVS, 1'b0, 32'h0000FF80, 16'h0001, 32'h00000080, 1'b0, 9,  1'b0);
      issue("divs_b_posov", MD_DIVS, 1'b0, 32'h00000080, 16'h0001, 32'h00000080, 1'b1, 9,  1'b0);
      issue("divs_b_negov", MD_DIVS, 1'b0, 32'h0000FF80, 16'h00FF, 32'h0000FF80, 1'b1, 9,  1'b0);

      for (int i = 0; i < 30; i++) rand_op($sformatf("rnd%0d", i));

      cen_tog = 1'b1;
      issue("mul_w_cen", MD_MUL, 1'b1, 32'h00001234, 16'h5678, 32'h06260060, 1'b0, 17, 1'b0);
      for (int i = 30; i < 55; i++) rand_op($sformatf("rnd%0d", i));
      cen_tog = 1'b0;

      issue("mul_rst", MD_MUL, 1'b1, 32'h0000ABCD, 16'h1234, 32'h0C374FA4, 1'b0, 17, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrun busy", md.busy, 0);
      chk("midrun done", md.done, 0);
      chk("midrun dout", md.dout, 0);
      chk("midrun ovf",  md.ovf,  0);
      sb.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      issue("div_after_rst", MD_DIV, 1'b1, 32'h00010000, 16'h0003, 32'h00015555, 1'b0, 17, 1'b0);
      for (int i = 55; i < 65; i++) rand_op($sformatf("rnd%0d", i));

      t = 0;
      while (sb.size() != 0 && t < 2000) begin @(negedge clk); t++; end
      repeat (2) @(negedge clk);
      chk("drain pending", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
